// File: rtl/boid_xcel_ctrl.sv
// Frame sequencer for the single-boid update datapath.
// Walks every boid: load self, stream neighbours, write back, advance.
module boid_xcel_ctrl #(
   parameter int N_BOIDS = 32,
   parameter int ADDR_W  = 5,
   parameter int RD_LAT  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic              acc_clr,
   output logic              r_en_tot,
   output logic              r_en_itr,
   output logic [ADDR_W-1:0] cur_boid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ITR,
      S_DRAIN,
      S_WRITE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_BOIDS - 1);

   // The return pipeline below assumes single-cycle memory reads.
   if (RD_LAT != 1) begin : g_bad_lat
      $error("boid_xcel_ctrl supports RD_LAT == 1 only");
   end

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] i_q, i_d;
   logic [ADDR_W-1:0] j_q, j_d;
   logic              tot_q, tot_d;
   logic              vld_q, vld_d;
   logic              skip_q, skip_d;

   // State, counters and read-return tracking flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         tot_q   <= 1'b0;
         vld_q   <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         tot_q   <= tot_d;
         vld_q   <= vld_d;
         skip_q  <= skip_d;
      end
   end

   // Next-state, counter update and memory/datapath strobes.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      done        = 1'b0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      mem_wr_en   = 1'b0;
      mem_wr_addr = '0;
      acc_clr     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               i_d     = '0;
            end
         end
         S_LOAD: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = i_q;
            acc_clr     = 1'b1;
            j_d         = '0;
            state_d     = S_ITR;
         end
         S_ITR: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = j_q;
            if (j_q == LAST) begin
               state_d = S_DRAIN;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         S_DRAIN: begin
            state_d = S_WRITE;
         end
         S_WRITE: begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = i_q;
            if (i_q == LAST) begin
               done    = 1'b1;
               i_d     = '0;
               state_d = S_IDLE;
            end else begin
               i_d     = i_q + 1'b1;
               state_d = S_LOAD;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Tag each issued read so its returned word lands in the right place.
   always_comb begin
      tot_d  = (state_q == S_LOAD);
      vld_d  = (state_q == S_ITR);
      skip_d = (state_q == S_ITR) && (j_q == i_q);
   end

   assign r_en_tot = tot_q;
   assign r_en_itr = vld_q & ~skip_q;
   assign busy     = (state_q != S_IDLE);
   assign cur_boid = i_q;

endmodule

// File: tb/tb_boid_xcel_ctrl.sv
// Scoreboard bench for boid_xcel_ctrl at N_BOIDS = 4, 32 and 2.
// Expected per-cycle strobe words are queued when a start is driven.
module tb_boid_xcel_ctrl;

   localparam int NB [3] = '{4, 32, 2};

   logic       clk = 1'b0;
   logic       rst [3];
   logic       start [3];
   logic       busy [3];
   logic       done [3];
   logic       rd_en [3];
   logic [4:0] rd_addr [3];
   logic       wr_en [3];
   logic [4:0] wr_addr [3];
   logic       acc_clr [3];
   logic       r_tot [3];
   logic       r_itr [3];
   logic [4:0] cur [3];

   logic [21:0] exp_q [3][$];

   int n_vec = 0;
   int n_err = 0;
   int done_cnt [3] = '{0, 0, 0};
   int tot_wr [3]   = '{0, 0, 0};
   int fcnt [3]     = '{0, 0, 0};
   int fwrc [3]     = '{0, 0, 0};
   int fitrc [3]    = '{0, 0, 0};
   int flen [3]     = '{0, 0, 0};
   int fwr [3]      = '{0, 0, 0};
   int fitr [3]     = '{0, 0, 0};
   bit last_busy [3] = '{1'b0, 1'b0, 1'b0};
   bit last_done [3] = '{1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      boid_xcel_ctrl #(
         .N_BOIDS(NB[g]),
         .ADDR_W (5),
         .RD_LAT (1)
      ) u_dut (
         .clk        (clk),
         .reset      (rst[g]),
         .start      (start[g]),
         .busy       (busy[g]),
         .done       (done[g]),
         .mem_rd_en  (rd_en[g]),
         .mem_rd_addr(rd_addr[g]),
         .mem_wr_en  (wr_en[g]),
         .mem_wr_addr(wr_addr[g]),
         .acc_clr    (acc_clr[g]),
         .r_en_tot   (r_tot[g]),
         .r_en_itr   (r_itr[g]),
         .cur_boid   (cur[g])
      );
   end

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [21:0] mk(int b, int d, int re, int ra,
                                      int we, int wa, int a, int t,
                                      int it, int c);
      logic [4:0] ra5, wa5, c5;
      ra5 = ra[4:0];
      wa5 = wa[4:0];
      c5  = c[4:0];
      return {b[0], d[0], re[0], ra5, we[0], wa5, a[0], t[0], it[0], c5};
   endfunction

   // One frame, straight from the sequencing description.
   task automatic push_frame(int k);
      int n;
      n = NB[k];
      for (int i = 0; i < n; i++) begin
         exp_q[k].push_back(mk(1, 0, 1, i, 0, 0, 1, 0, 0, i));
         for (int c = 0; c < n; c++) begin
            exp_q[k].push_back(mk(1, 0, 1, c, 0, 0, 0, int'(c == 0),
                                  int'(c > 0 && c - 1 != i), i));
         end
         exp_q[k].push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,
                               int'(n - 1 != i), i));
         exp_q[k].push_back(mk(1, int'(i == n - 1), 0, 0, 1, i,
                               0, 0, 0, i));
      end
   endtask

   // Per-cycle trace compare plus frame statistics.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         logic [21:0] w;
         logic [21:0] e;
         w = {busy[k], done[k], rd_en[k], rd_addr[k], wr_en[k],
              wr_addr[k], acc_clr[k], r_tot[k], r_itr[k], cur[k]};
         e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 22'd0;
         chk($sformatf("trace%0d", k), 32'(w), 32'(e));
         chk($sformatf("rdwr_ovl%0d", k), 32'(rd_en[k] & wr_en[k]), 0);
         if (wr_en[k]) tot_wr[k]++;
         if (!busy[k]) begin
            fcnt[k]  = 0;
            fwrc[k]  = 0;
            fitrc[k] = 0;
         end else begin
            fcnt[k]++;
            if (wr_en[k]) fwrc[k]++;
            if (r_itr[k]) fitrc[k]++;
            if (done[k]) begin
               flen[k] = fcnt[k];
               fwr[k]  = fwrc[k];
               fitr[k] = fitrc[k];
               done_cnt[k]++;
            end
         end
         last_busy[k] = busy[k];
         last_done[k] = done[k];
      end
   end

   task automatic to_neg;
      @(negedge clk);
      #1;
   endtask

   // Called at negedge+1: start is sampled at the next rising edge.
   task automatic pulse_now(int k);
      start[k] = 1'b1;
      if (!last_busy[k] && !rst[k]) push_frame(k);
      @(posedge clk);
      #1;
      start[k] = 1'b0;
   endtask

   task automatic wait_frame(int k);
      int n;
      int d0;
      int c;
      n  = NB[k];
      d0 = done_cnt[k];
      c  = 0;
      while (done_cnt[k] == d0 && c < n * (n + 3) + 20) begin
         to_neg;
         c++;
      end
      chk($sformatf("done_seen%0d", k), done_cnt[k] - d0, 1);
      chk($sformatf("frame_len%0d", k), flen[k], n * (n + 3));
      chk($sformatf("wr_cnt%0d", k), fwr[k], n);
      chk($sformatf("itr_cnt%0d", k), fitr[k], n * (n - 1));
   endtask

   initial begin
      int d0;
      int w0;
      int c;
      for (int k = 0; k < 3; k++) begin
         rst[k]   = 1'b1;
         start[k] = 1'b0;
      end
      repeat (3) to_neg;
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      repeat (2) to_neg;

      // Full frame at N=4, then a hammered start.
      pulse_now(0);
      wait_frame(0);
      repeat (3) to_neg;

      pulse_now(0);
      d0 = done_cnt[0];
      c  = 0;
      to_neg;
      while (!last_done[0] && c < 100) begin
         pulse_now(0);
         to_neg;
         c++;
      end
      chk("hammer_done", done_cnt[0] - d0, 1);
      pulse_now(0);
      to_neg;
      pulse_now(0);
      wait_frame(0);
      repeat (3) to_neg;

      // Reset during ITR of boid 1 abandons the frame.
      pulse_now(0);
      to_neg;
      repeat (9) to_neg;
      rst[0] = 1'b1;
      exp_q[0].delete();
      w0 = tot_wr[0];
      d0 = done_cnt[0];
      to_neg;
      chk("rst_busy", 32'(busy[0]), 0);
      to_neg;
      rst[0] = 1'b0;
      repeat (60) to_neg;
      chk("rst_no_wr", tot_wr[0] - w0, 0);
      chk("rst_no_done", done_cnt[0] - d0, 0);

      // Default size and the smallest size.
      pulse_now(1);
      wait_frame(1);
      to_neg;
      pulse_now(2);
      wait_frame(2);
      repeat (5) to_neg;

      for (int k = 0; k < 3; k++) begin
         chk($sformatf("q_empty%0d", k), exp_q[k].size(), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/boid_xcel_ctrl.md
Name: boid_xcel_ctrl

Overview:
Sequencer for the single-boid update datapath (position/velocity regs, neighbour accumulators, writeback).
For each boid i it does four things:
- loads boid i into the self registers;
- streams every other boid j past the accumulators;
- writes the updated boid back to boid memory;
- advances to the next boid.
One `start` pulse runs one full frame over all boids, then pulses `done`. The block sits between the frame-tick logic (VGA vsync domain, already synchronous to `clk`) and the M10K boid memory plus datapath.

Parameters:
N_BOIDS, 32, number of boids in memory (2..2^ADDR_W)
ADDR_W, 5, boid memory address width
RD_LAT, 1, M10K read latency in cycles (fixed 1; other values are out of scope)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to run one frame; ignored unless in IDLE
busy  out  1  high from the cycle after accepted `start` until `done` cycle inclusive
done  out  1  one-cycle pulse when the last boid write completes
mem_rd_en  out  1  boid memory read strobe
mem_rd_addr  out  ADDR_W  boid memory read address
mem_wr_en  out  1  boid memory write strobe (datapath outputs are the write data)
mem_wr_addr  out  ADDR_W  boid memory write address
acc_clr  out  1  clears datapath accumulators (avg, close, neighbour counter) to 0
r_en_tot  out  1  latch memory read data into the self x/y/vx/vy regs
r_en_itr  out  1  accumulate memory read data into neighbour accumulators
cur_boid  out  ADDR_W  index i currently being updated (debug/status)

Behaviour:
- Reset (sync, active-high, any state):
  - state=IDLE, i=0, j=0;
  - all outputs 0, including the read-pipeline valid/skip flops.
  - Reset mid-frame abandons the frame: no further writes and no `done` pulse.
- States: IDLE, LOAD, ITR, DRAIN, WRITE.
- IDLE:
  - `start`=1 -> LOAD with i=0, and `busy` asserts next cycle.
  - `start` in any other state is ignored; it is not queued.
- LOAD (1 cycle): mem_rd_en=1, mem_rd_addr=i, acc_clr=1. Next state is ITR with j=0.
- ITR (N_BOIDS cycles):
  - Outputs: mem_rd_en=1, mem_rd_addr=j, j increments each cycle.
  - r_en_tot=1 only in the first ITR cycle, when boid i's data returns.
  - Exit: when j==N_BOIDS-1 -> DRAIN.
- Read return pipeline:
  - A 1-cycle delayed valid flag and skip flag track each ITR read; skip = (j==i) at issue.
  - r_en_itr = delayed_valid & ~delayed_skip. The self boid is never accumulated.
  - r_en_itr and r_en_tot are never both high for the same returned word.
- DRAIN (1 cycle): no read. r_en_itr may be high for the last returned word (j=N_BOIDS-1). Next state is WRITE.
- WRITE (1 cycle):
  - mem_wr_en=1, mem_wr_addr=i.
  - If i==N_BOIDS-1: done=1, next state IDLE, i=0.
  - Otherwise: i increments, next state LOAD.
- Timing:
  - Per boid: N_BOIDS+3 cycles.
  - Frame: N_BOIDS*(N_BOIDS+3) cycles from the first LOAD to the `done` cycle inclusive. For defaults this is 1120.
- Update order: in-place sequential. Boid k>i reads boid i's already-updated value.
- Read/write overlap: mem_rd_en and mem_wr_en are never high in the same cycle.
- Counters: i and j are ADDR_W bits. They never wrap past N_BOIDS-1; comparisons are against N_BOIDS-1, not 2^ADDR_W-1.
- Timing of `start` relative to `done`: `start` in the same cycle as `done` is ignored; state is still WRITE. `start` one cycle later is accepted.
- cur_boid = i; it is held in IDLE (0).

Test Plan:
1. Reset then `start` pulse, N_BOIDS=4 -> LOAD/ITR/DRAIN/WRITE sequence per boid. `done` pulses exactly 28 cycles after the first LOAD cycle inclusive. mem_wr_addr sequence is 0,1,2,3. `busy` drops the cycle after `done`.
2. Per-boid strobe check, N_BOIDS=4, boid i=2:
   - mem_rd_addr sequence is 2,0,1,2,3;
   - r_en_tot is high one cycle after the LOAD read;
   - r_en_itr is high exactly 3 times, for returned words j=0,1,3 (j=2 skipped);
   - acc_clr is high only in LOAD.
3. `start` asserted repeatedly during a frame -> ignored; exactly one `done`. `start` in the `done` cycle is ignored; `start` the next cycle begins a new frame at i=0.
4. Reset asserted during ITR of boid 1 -> next cycle all outputs 0, state IDLE. No mem_wr_en and no `done` afterwards without a new `start`.
5. N_BOIDS=32 default, full frame -> `done` 1120 cycles after the first LOAD. 32 write strobes and 32*31=992 r_en_itr pulses total. mem_rd_en&mem_wr_en never both high.
6. Boundary N_BOIDS=2:
   - boid 0: r_en_itr once (j=1);
   - boid 1: r_en_itr once (j=0);
   - frame length is 10 cycles.
